// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared constants and entry type for the decoupled fetch queue
package if_fetch_queue_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        nextPc;
  } fetchEntry_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue bus: redirect, imem request/response and ID-side handshake
interface if_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_next_pc;
  logic        id_ready;
  logic [31:0] fetch_pc;

  modport master (
    input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_next_pc, fetch_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_next_pc, fetch_pc
  );
endinterface

// File: rtl/if_fetch_queue_sync_fifo.sv
// rtl/if_fetch_queue_sync_fifo.sv - registered FIFO with flush; pointers carry an extra wrap bit
module if_fetch_queue_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             full;
  logic             pushOk;

  assign count   = wrPtr - rdPtr;
  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign pushOk  = push & ~full;
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop && !empty) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk && !reset && !flush) mem[wrPtr[AW-1:0]] <= pushData;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - decoupled IF stage: tracks in-flight imem requests, buffers words for ID
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_queue_if.master  bus
);
  localparam int CNT_W = $clog2(maxInt(DEPTH, MAX_OUT) + 1);
  localparam int FC_W  = $clog2(DEPTH) + 1;
  localparam int ENT_W = $bits(fetchEntry_t);

  logic [31:0]      fetchPc;
  logic [31:0]      rspPc;
  logic [CNT_W-1:0] live;
  logic [CNT_W-1:0] stale;
  logic [FC_W-1:0]  count;
  logic             empty;
  logic             canReq;
  logic             reqFire;
  logic             rspStale;
  logic             rspLive;
  logic             rspTaken;
  logic             pushEn;
  logic             popEn;
  logic             idValid;
  logic [31:0]      redirTarget;
  fetchEntry_t      pushEntry;
  fetchEntry_t      headEntry;
  logic [ENT_W-1:0] headBits;

  assign redirTarget = {bus.redirect_pc[31:2], 2'b00};

  // Buffer slots are reserved at request time so a returning word always has room.
  assign canReq = ((int'(count) + int'(live)) < DEPTH) && ((int'(live) + int'(stale)) < MAX_OUT);
  assign bus.imem_req_valid = ~reset & ~bus.redirect & canReq;
  assign bus.imem_req_addr  = fetchPc;
  assign bus.fetch_pc       = fetchPc;
  assign reqFire            = bus.imem_req_valid & bus.imem_req_ready;

  assign rspStale = bus.imem_rsp_valid & (stale != '0);
  assign rspLive  = bus.imem_rsp_valid & (stale == '0) & (live != '0);
  assign rspTaken = rspStale | rspLive;
  assign pushEn   = rspLive & ~bus.redirect & ~reset;

  assign pushEntry.instr  = bus.imem_rsp_data;
  assign pushEntry.nextPc = rspPc + PC_STEP;

  assign idValid        = ~reset & ~empty;
  assign popEn          = idValid & bus.id_ready & ~bus.redirect;
  assign headEntry      = fetchEntry_t'(headBits);
  assign bus.id_valid   = idValid;
  assign bus.id_instr   = idValid ? headEntry.instr  : '0;
  assign bus.id_next_pc = idValid ? headEntry.nextPc : '0;

  if_fetch_queue_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.redirect),
    .push     (pushEn),
    .pushData (pushEntry),
    .pop      (popEn),
    .popData  (headBits),
    .count    (count),
    .empty    (empty)
  );

  // On redirect every live request turns stale; a response in this same cycle retires one of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc <= RESET_PC;
      rspPc   <= RESET_PC;
      live    <= '0;
      stale   <= '0;
    end else if (bus.redirect) begin
      fetchPc <= redirTarget;
      rspPc   <= redirTarget;
      live    <= '0;
      stale   <= stale + live - CNT_W'(rspTaken);
    end else begin
      if (reqFire) fetchPc <= fetchPc + PC_STEP;
      if (rspLive) rspPc   <= rspPc + PC_STEP;
      if (rspStale) stale  <= stale - CNT_W'(1);
      live <= live + CNT_W'(reqFire) - CNT_W'(rspLive);
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized bench for if_fetch_queue against an architectural fetch-order model
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic reset;
  if_fetch_queue_if bus ();

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  pend_t       pend[$];
  int          cyc = 0;
  int          lastDue = -10;
  logic [31:0] expPc = RESET_PC;
  logic [31:0] nextReqPc = RESET_PC;
  bit          afterRedir = 0;
  bit          rstReq = 1;
  int          reqReadyPct = 100;
  int          idReadyPct = 100;
  int          latMin = 1;
  int          latMax = 1;
  int          redirPct = 0;
  int          redirHold = 0;
  bit          forceRedir = 0;
  logic [31:0] forcePc = '0;
  bit          coincMode = 0;
  int          coincHits = 0;
  int          popCount = 0;
  int          reqCount = 0;
  int          firstPopCyc = -1;
  logic [31:0] firstInstr = '0;
  int          relBase = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] randTarget();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom & 32'h0000_FFFF;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic observe();
    int lat;
    int d;
    if (reset) begin
      checkVal("rst_id_valid", 32'(bus.id_valid), 32'd0);
      checkVal("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      checkVal("rst_id_instr", bus.id_instr, 32'd0);
      checkVal("rst_id_next_pc", bus.id_next_pc, 32'd0);
      if (bus.imem_rsp_valid) void'(pend.pop_front());
      expPc = RESET_PC;
      nextReqPc = RESET_PC;
      afterRedir = 0;
      return;
    end
    checkVal("fetch_pc", bus.fetch_pc, nextReqPc);
    if (afterRedir) checkVal("flush_empty", 32'(bus.id_valid), 32'd0);
    afterRedir = bus.redirect;
    if (bus.redirect) checkVal("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      checkVal("req_addr", bus.imem_req_addr, nextReqPc);
      lat = $urandom_range(latMax, latMin);
      d = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
      pend.push_back('{addr: nextReqPc, due: d});
      lastDue = d;
      nextReqPc = nextReqPc + 32'd4;
      reqCount++;
      checkVal("max_out", 32'(pend.size() <= MAX_OUT), 32'd1);
    end
    if (bus.id_valid && bus.id_ready && !bus.redirect) begin
      checkVal("id_instr", bus.id_instr, memWord(expPc));
      checkVal("id_next_pc", bus.id_next_pc, expPc + 32'd4);
      if (firstPopCyc < 0) begin
        firstPopCyc = cyc;
        firstInstr = bus.id_instr;
      end
      expPc = expPc + 32'd4;
      popCount++;
    end
    if (bus.redirect) begin
      expPc = {bus.redirect_pc[31:2], 2'b00};
      nextReqPc = expPc;
    end
    if (bus.imem_rsp_valid) void'(pend.pop_front());
  endtask

  task automatic tick();
    reset = rstReq;
    bus.imem_req_ready = ($urandom_range(99) < reqReadyPct);
    bus.id_ready = ($urandom_range(99) < idReadyPct);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = memWord(pend[0].addr);
    end
    bus.redirect = 1'b0;
    if (forceRedir) begin
      bus.redirect = 1'b1;
      bus.redirect_pc = forcePc;
      forceRedir = 0;
    end else if (coincMode && bus.id_valid && bus.id_ready && bus.imem_rsp_valid) begin
      bus.redirect = 1'b1;
      bus.redirect_pc = $urandom & 32'h0000_0FFC;
      coincMode = 0;
      coincHits++;
    end else if (redirHold > 0) begin
      bus.redirect = 1'b1;
      redirHold--;
    end else if ($urandom_range(99) < redirPct) begin
      bus.redirect = 1'b1;
      bus.redirect_pc = randTarget();
      redirHold = $urandom_range(1);
    end
    #4;
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset(input int n);
    rstReq = 1;
    repeat (n) tick();
    rstReq = 0;
    popCount = 0;
    reqCount = 0;
    firstPopCyc = -1;
    relBase = cyc;
  endtask

  initial begin
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.id_ready = 1'b0;
    @(posedge clk);
    #1;

    // Streaming with latency 1: fill in two cycles, then one word per cycle.
    doReset(3);
    repeat (22) tick();
    checkVal("t1_first_valid", 32'(firstPopCyc - relBase), 32'd2);
    checkVal("t1_throughput", 32'(popCount), 32'd20);

    // ID stalled: exactly DEPTH requests, then drained in order.
    doReset(2);
    idReadyPct = 0;
    repeat (10) tick();
    checkVal("t2_req_count", 32'(reqCount), 32'(DEPTH));
    checkVal("t2_full_valid", 32'(bus.id_valid), 32'd1);
    reqReadyPct = 0;
    idReadyPct = 100;
    repeat (6) tick();
    checkVal("t2_drained", 32'(popCount), 32'(DEPTH));
    checkVal("t2_empty", 32'(bus.id_valid), 32'd0);

    // Latency 3, redirect with two requests in flight.
    reqReadyPct = 100;
    latMin = 3;
    latMax = 3;
    doReset(2);
    tick();
    tick();
    forceRedir = 1;
    forcePc = 32'h0000_0100;
    tick();
    repeat (10) tick();
    checkVal("t3_first_cycle", 32'(firstPopCyc - relBase), 32'd7);
    checkVal("t3_first_instr", firstInstr, memWord(32'h100));

    // Redirect landing together with a response and a pop.
    coincMode = 1;
    repeat (30) tick();
    checkVal("t4_coincident_seen", 32'(coincHits), 32'd1);

    // Unaligned target near the top of memory: low bits dropped, PC wraps to 0.
    latMin = 1;
    latMax = 1;
    forceRedir = 1;
    forcePc = 32'hFFFF_FFF6;
    popCount = 0;
    repeat (14) tick();
    checkVal("t5_wrap_progress", 32'(popCount >= 8), 32'd1);

    // Random ready, latency and redirects.
    reqReadyPct = 50;
    latMin = 1;
    latMax = 4;
    idReadyPct = 70;
    redirPct = 4;
    popCount = 0;
    repeat (3000) tick();
    checkVal("t6_progress", 32'(popCount > 300), 32'd1);

    // Reset with requests in flight; late responses must be ignored.
    redirPct = 0;
    redirHold = 0;
    while (bus.redirect === 1'b1) tick();
    reqReadyPct = 100;
    latMin = 4;
    latMax = 4;
    idReadyPct = 0;
    repeat (3) tick();
    doReset(1);
    reqReadyPct = 0;
    for (int i = 0; i < 12 && pend.size() > 0; i++) tick();
    checkVal("t7_drained", 32'(pend.size()), 32'd0);
    checkVal("t7_no_valid", 32'(bus.id_valid), 32'd0);
    checkVal("t7_fetch_pc", bus.fetch_pc, RESET_PC);
    reqReadyPct = 100;
    idReadyPct = 100;
    latMin = 1;
    latMax = 1;
    popCount = 0;
    firstPopCyc = -1;
    repeat (12) tick();
    checkVal("t7_restart_instr", firstInstr, memWord(RESET_PC));
    checkVal("t7_restart_count", 32'(popCount), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
